// File: rtl/status_flag_unit.sv
// Registered C/Z/N/V flag file for NUM_ACC accumulators with bypassed read and a save/restore stack.
// Optional feature: define STATUS_OVF_EN to store the V flag (otherwise V reads as constant 0).
module status_flag_unit #(
  parameter int DATA_W      = 8,
  parameter int NUM_ACC     = 2,
  parameter int STACK_DEPTH = 4,
  localparam int AW         = (NUM_ACC > 1) ? $clog2(NUM_ACC) : 1
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 upd_valid,
  input  logic [AW-1:0]        upd_acc,
  input  logic [1:0]           upd_mode,
  input  logic                 alu_carry,
  input  logic                 alu_zero,
  input  logic                 alu_sign,
  input  logic                 alu_ovf,
  input  logic [DATA_W-1:0]    ld_data,
  input  logic [3:0]           wr_flags,
  input  logic                 push,
  input  logic                 pop,
  input  logic [AW-1:0]        rd_acc,
  output logic [3:0]           rd_flags,
  output logic [4*NUM_ACC-1:0] flags_out,
  output logic                 stk_full,
  output logic                 stk_empty,
  output logic                 stk_err
);

  localparam int FW  = 4 * NUM_ACC;
  localparam int SPW = $clog2(STACK_DEPTH + 1);
  localparam int IW  = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;

`ifdef STATUS_OVF_EN
  localparam logic [3:0] NIB_MASK = 4'hF;
`else
  localparam logic [3:0] NIB_MASK = 4'h7;
`endif
  localparam logic [FW-1:0] FLAG_MASK = {NUM_ACC{NIB_MASK}};

  typedef enum logic [1:0] {
    MODE_NONE  = 2'b00,
    MODE_ALU   = 2'b01,
    MODE_LOAD  = 2'b10,
    MODE_WRITE = 2'b11
  } mode_e;

  logic [FW-1:0]  flags_q;
  logic [FW-1:0]  flags_nxt;
  logic [FW-1:0]  stack_mem [STACK_DEPTH];
  logic [SPW-1:0] sp;
  logic           err_q;
  logic           push_ok, pop_ok, misuse;
  logic [IW-1:0]  wr_idx, rd_idx;
  mode_e          mode;

  assign stk_full  = (sp == SPW'(STACK_DEPTH));
  assign stk_empty = (sp == '0);
  assign stk_err   = err_q;
  assign flags_out = flags_q;

  assign push_ok = push & ~pop & ~stk_full;
  assign pop_ok  = pop & ~push & ~stk_empty;
  assign misuse  = (push & pop) | (push & stk_full) | (pop & stk_empty);
  assign wr_idx  = IW'(sp);
  assign rd_idx  = IW'(sp - 1'b1);
  assign mode    = mode_e'(upd_mode);

  // A legal pop restores the whole vector and drops any same-cycle update.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path infers a latch.
    flags_nxt = flags_q;
    if (pop_ok) begin
      flags_nxt = stack_mem[rd_idx];
    end else if (upd_valid) begin
      for (int k = 0; k < NUM_ACC; k++) begin
        if (upd_acc == AW'(k)) begin
          unique case (mode)
            MODE_ALU:   flags_nxt[4*k +: 4] = {alu_ovf, alu_sign, alu_zero, alu_carry};
            MODE_LOAD:  flags_nxt[4*k +: 4] = {flags_q[4*k+3], ld_data[DATA_W-1],
                                               ~|ld_data, flags_q[4*k]};
            MODE_WRITE: flags_nxt[4*k +: 4] = wr_flags;
            default:    flags_nxt[4*k +: 4] = flags_q[4*k +: 4];
          endcase
        end
      end
    end
    flags_nxt = flags_nxt & FLAG_MASK;
  end

  always_comb begin
    rd_flags = '0;
    for (int k = 0; k < NUM_ACC; k++) begin
      if (rd_acc == AW'(k)) rd_flags = flags_nxt[4*k +: 4];
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so all flops update from pre-edge values.
    if (!reset_n) begin
      flags_q <= '0;
      sp      <= '0;
      err_q   <= 1'b0;
    end else begin
      flags_q <= flags_nxt;
      if (push_ok)     sp <= sp + 1'b1;
      else if (pop_ok) sp <= sp - 1'b1;
      if (misuse)      err_q <= 1'b1;
    end
  end

  // NOTE: stack storage has no reset; entries are only read after a push has written them.
  always_ff @(posedge clk) begin
    if (reset_n && push_ok) stack_mem[wr_idx] <= flags_q;
  end

endmodule

// File: tb/tb_status_flag_unit.sv
// Self-checking bench for status_flag_unit: directed scenarios plus random traffic against a
// queue-based reference model; a second NUM_ACC=3 instance covers out-of-range accumulator indices.
module tb_status_flag_unit;

  localparam int DATA_W      = 8;
  localparam int NUM_ACC     = 2;
  localparam int STACK_DEPTH = 4;
  localparam int AW          = 1;
  localparam int FW          = 4 * NUM_ACC;
`ifdef STATUS_OVF_EN
  localparam bit OVF_EN = 1'b1;
`else
  localparam bit OVF_EN = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              reset_n, upd_valid, push, pop;
  logic [AW-1:0]     upd_acc, rd_acc;
  logic [1:0]        upd_mode;
  logic              alu_carry, alu_zero, alu_sign, alu_ovf;
  logic [DATA_W-1:0] ld_data;
  logic [3:0]        wr_flags, rd_flags;
  logic [FW-1:0]     flags_out;
  logic              stk_full, stk_empty, stk_err;

  logic              t3_reset_n, t3_upd_valid;
  logic [1:0]        t3_upd_acc, t3_rd_acc, t3_upd_mode;
  logic [3:0]        t3_wr_flags, t3_rd_flags;
  logic [11:0]       t3_flags_out;
  logic              t3_full, t3_empty, t3_err;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  status_flag_unit #(.DATA_W(DATA_W), .NUM_ACC(NUM_ACC), .STACK_DEPTH(STACK_DEPTH)) u_dut (
    .clk(clk), .reset_n(reset_n), .upd_valid(upd_valid), .upd_acc(upd_acc), .upd_mode(upd_mode),
    .alu_carry(alu_carry), .alu_zero(alu_zero), .alu_sign(alu_sign), .alu_ovf(alu_ovf),
    .ld_data(ld_data), .wr_flags(wr_flags), .push(push), .pop(pop), .rd_acc(rd_acc),
    .rd_flags(rd_flags), .flags_out(flags_out), .stk_full(stk_full), .stk_empty(stk_empty),
    .stk_err(stk_err)
  );

  status_flag_unit #(.DATA_W(DATA_W), .NUM_ACC(3), .STACK_DEPTH(2)) u_dut3 (
    .clk(clk), .reset_n(t3_reset_n), .upd_valid(t3_upd_valid), .upd_acc(t3_upd_acc),
    .upd_mode(t3_upd_mode), .alu_carry(1'b1), .alu_zero(1'b1), .alu_sign(1'b1), .alu_ovf(1'b1),
    .ld_data(8'h00), .wr_flags(t3_wr_flags), .push(1'b0), .pop(1'b0), .rd_acc(t3_rd_acc),
    .rd_flags(t3_rd_flags), .flags_out(t3_flags_out), .stk_full(t3_full), .stk_empty(t3_empty),
    .stk_err(t3_err)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: one 4-bit {V,N,Z,C} value per accumulator, stack as a queue of snapshots.
  logic [3:0]    m_flags [NUM_ACC];
  logic [3:0]    n_flags [NUM_ACC];
  logic [FW-1:0] m_stack [$];
  bit            m_err, n_push, n_pop, n_err;

  function automatic logic [FW-1:0] snapshot();
    logic [FW-1:0] v;
    for (int a = 0; a < NUM_ACC; a++) v[4*a +: 4] = m_flags[a];
    return v;
  endfunction

  task automatic model_eval();
    logic c, z, n, v;
    logic [FW-1:0] top;
    int depth;
    depth  = m_stack.size();
    n_err  = (push && pop) || (push && depth == STACK_DEPTH) || (pop && depth == 0);
    n_push = push && !pop && depth < STACK_DEPTH;
    n_pop  = pop && !push && depth > 0;
    n_flags = m_flags;
    if (n_pop) begin
      top = m_stack[depth-1];
      for (int a = 0; a < NUM_ACC; a++) n_flags[a] = top[4*a +: 4];
    end else if (upd_valid && upd_mode != 2'b00 && int'(upd_acc) < NUM_ACC) begin
      {v, n, z, c} = m_flags[upd_acc];
      if (upd_mode == 2'b01) begin
        c = alu_carry; z = alu_zero; n = alu_sign; v = alu_ovf;
      end else if (upd_mode == 2'b10) begin
        z = (ld_data == 0); n = ld_data[DATA_W-1];
      end else begin
        {v, n, z, c} = wr_flags;
      end
      if (!OVF_EN) v = 1'b0;
      n_flags[upd_acc] = {v, n, z, c};
    end
  endtask

  task automatic model_commit();
    if (!reset_n) begin
      foreach (m_flags[a]) m_flags[a] = 4'h0;
      m_stack.delete();
      m_err = 1'b0;
    end else begin
      if (n_push) m_stack.push_back(snapshot());
      if (n_pop)  void'(m_stack.pop_back());
      m_flags = n_flags;
      if (n_err) m_err = 1'b1;
    end
  endtask

  // Inputs are set at a falling edge; this checks the bypass, clocks once, then checks state.
  task automatic run_cycle();
    logic [3:0] exp_rd;
    #1;
    model_eval();
    exp_rd = (int'(rd_acc) < NUM_ACC) ? n_flags[rd_acc] : 4'h0;
    if (reset_n) check("rd_flags", rd_flags, exp_rd);
    @(posedge clk);
    model_commit();
    @(negedge clk);
    check("flags_out", flags_out, snapshot());
    check("stk_full", stk_full, m_stack.size() == STACK_DEPTH);
    check("stk_empty", stk_empty, m_stack.size() == 0);
    check("stk_err", stk_err, m_err);
  endtask

  task automatic set_idle();
    reset_n = 1'b1; upd_valid = 1'b0; upd_acc = '0; upd_mode = 2'b00;
    {alu_carry, alu_zero, alu_sign, alu_ovf} = 4'h0;
    ld_data = '0; wr_flags = 4'h0; push = 1'b0; pop = 1'b0; rd_acc = '0;
  endtask

  task automatic do_write(input logic [AW-1:0] acc, input logic [3:0] f);
    set_idle(); upd_valid = 1'b1; upd_mode = 2'b11; upd_acc = acc; wr_flags = f; rd_acc = acc;
    run_cycle();
  endtask

  task automatic do_reset();
    set_idle(); reset_n = 1'b0; run_cycle();
  endtask

  initial begin
    set_idle();
    t3_reset_n = 1'b0; t3_upd_valid = 1'b0; t3_upd_acc = 2'd0; t3_upd_mode = 2'b00;
    t3_wr_flags = 4'h0; t3_rd_acc = 2'd0;
    foreach (m_flags[a]) m_flags[a] = 4'h0;
    m_err = 1'b0;

    do_reset();
    check("rst_flags", flags_out, 0);
    check("rst_empty", stk_empty, 1);
    check("rst_err", stk_err, 0);

    // ALU update on acc 1.
    set_idle(); upd_valid = 1'b1; upd_mode = 2'b01; upd_acc = 1'b1; rd_acc = 1'b1;
    {alu_carry, alu_zero, alu_sign, alu_ovf} = 4'b1011;
    run_cycle();
    check("alu_acc1", flags_out[7:4], OVF_EN ? 4'b1101 : 4'b0101);
    check("alu_acc0", flags_out[3:0], 4'b0000);

    // LOAD with C preset.
    do_write(1'b0, 4'b0001);
    set_idle(); upd_valid = 1'b1; upd_mode = 2'b10; ld_data = 8'h00; run_cycle();
    check("load_zero", flags_out[3:0], 4'b0011);
    set_idle(); upd_valid = 1'b1; upd_mode = 2'b10; ld_data = 8'h80; run_cycle();
    check("load_neg", flags_out[3:0], 4'b0101);

    // Push with same-cycle WRITE, then pop restores pre-update value.
    do_write(1'b0, 4'b0001);
    do_write(1'b1, 4'b0000);
    set_idle(); push = 1'b1; upd_valid = 1'b1; upd_mode = 2'b11; wr_flags = 4'b0100; run_cycle();
    check("push_upd", flags_out[3:0], 4'b0100);
    check("push_nempty", stk_empty, 0);
    set_idle(); pop = 1'b1; run_cycle();
    check("pop_restore", flags_out[3:0], 4'b0001);
    check("pop_empty", stk_empty, 1);

    // Overflow the stack.
    for (int i = 0; i <= STACK_DEPTH; i++) begin
      set_idle(); push = 1'b1; run_cycle();
    end
    check("ovf_full", stk_full, 1);
    check("ovf_err", stk_err, 1);

    // Pop on empty after reset.
    do_reset();
    set_idle(); pop = 1'b1; upd_valid = 1'b1; upd_mode = 2'b11; wr_flags = 4'b0010; run_cycle();
    check("pop_empty_err", stk_err, 1);
    check("pop_empty_upd", flags_out[3:0], 4'b0010);

    // Legal pop beats a same-cycle ALU update; push+pop together changes nothing.
    do_reset();
    do_write(1'b1, 4'b0010);
    set_idle(); push = 1'b1; run_cycle();
    set_idle(); pop = 1'b1; upd_valid = 1'b1; upd_mode = 2'b01; upd_acc = 1'b1; rd_acc = 1'b1;
    {alu_carry, alu_zero, alu_sign, alu_ovf} = 4'b1111;
    run_cycle();
    check("pop_wins", flags_out[7:4], 4'b0010);
    set_idle(); push = 1'b1; run_cycle();
    set_idle(); push = 1'b1; pop = 1'b1; run_cycle();
    check("pushpop_err", stk_err, 1);
    check("pushpop_flags", flags_out[7:4], 4'b0010);

    // Reset asserted during a push.
    set_idle(); reset_n = 1'b0; push = 1'b1; run_cycle();
    check("rstpush_empty", stk_empty, 1);
    check("rstpush_flags", flags_out, 0);
    check("rstpush_err", stk_err, 0);

    // Random traffic.
    for (int i = 0; i < 3000; i++) begin
      reset_n   = ($urandom_range(0, 79) != 0);
      upd_valid = ($urandom_range(0, 3) != 0);
      upd_acc   = AW'($urandom_range(0, NUM_ACC - 1));
      upd_mode  = 2'($urandom);
      {alu_carry, alu_zero, alu_sign, alu_ovf} = 4'($urandom);
      ld_data   = ($urandom_range(0, 3) == 0) ? '0 : DATA_W'($urandom);
      wr_flags  = 4'($urandom);
      push      = ($urandom_range(0, 3) == 0);
      pop       = ($urandom_range(0, 3) == 0);
      rd_acc    = AW'($urandom_range(0, NUM_ACC - 1));
      run_cycle();
    end

    // Out-of-range accumulator index on the three-accumulator instance.
    set_idle();
    @(posedge clk); @(negedge clk);
    t3_reset_n = 1'b1; t3_upd_valid = 1'b1; t3_upd_mode = 2'b01; t3_upd_acc = 2'd3; t3_rd_acc = 2'd3;
    #1;
    check("t3_rd_oob", t3_rd_flags, 4'h0);
    @(posedge clk); @(negedge clk);
    check("t3_upd_oob", t3_flags_out, 12'h000);
    t3_upd_mode = 2'b11; t3_upd_acc = 2'd2; t3_wr_flags = 4'b0110; t3_rd_acc = 2'd2;
    #1;
    check("t3_rd_acc2", t3_rd_flags, 4'b0110);
    @(posedge clk); @(negedge clk);
    check("t3_acc2", t3_flags_out, 12'h600);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
